// File: rtl/feeder_pkg.sv
// Shared FSM encodings and default timing for the pet-feeder blocks.
// Ports: none (package only).
package feeder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPENSE = 2'd1,
      ST_EMPTY    = 2'd2
   } feed_state_e;

   // Defaults assume a 50 MHz clock.
   localparam int DEF_DEBOUNCE_CYCLES = 500_000;
   localparam int DEF_MOTOR_CYCLES    = 25_000_000;
   localparam int DEF_MAX_PORTIONS    = 8;
   localparam int DEF_CNT_W           = 4;

   // Bits needed to hold values 0..n (never less than 1).
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, debounce, rising-edge pulse.
// Ports: clk, rst_n (sync, active-low), btn_raw in, pulse out.
module btn_debounce
   import feeder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic pulse
);

   localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            level_q, level_d;
   logic            edge_q, edge_d;
   logic            pulse_q, pulse_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      // Count consecutive disagreement; any agreement clears it.
      if (sync2_q != level_q) begin
         if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      edge_d  = level_q;
      pulse_d = level_q & ~edge_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         edge_q  <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         edge_q  <= edge_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/portion_monitor.sv
// Feeder portion tracker: runs the motor per dispense, flags empty.
// Ports: clk_50mhz, rst_n, btn_dispense, btn_refill in;
//        motor_en, busy, portions[CNT_W], trigger out (all registered).
module portion_monitor
   import feeder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int MOTOR_CYCLES    = DEF_MOTOR_CYCLES,
   parameter int MAX_PORTIONS    = DEF_MAX_PORTIONS,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic             clk_50mhz,
   input  logic             rst_n,
   input  logic             btn_dispense,
   input  logic             btn_refill,
   output logic             motor_en,
   output logic             busy,
   output logic [CNT_W-1:0] portions,
   output logic             trigger
);

   localparam int TMR_W = cnt_width(MOTOR_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MOTOR_CYCLES);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [CNT_W-1:0] P_FULL   = CNT_W'(MAX_PORTIONS);
   localparam logic [CNT_W-1:0] P_ONE    = CNT_W'(1);

   logic disp_p;
   logic refill_p;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_disp (
      .clk    (clk_50mhz),
      .rst_n  (rst_n),
      .btn_raw(btn_dispense),
      .pulse  (disp_p)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_refill (
      .clk    (clk_50mhz),
      .rst_n  (rst_n),
      .btn_raw(btn_refill),
      .pulse  (refill_p)
   );

   feed_state_e      state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] portions_q, portions_d;
   logic             motor_q, motor_d;
   logic             busy_q, busy_d;
   logic             trigger_q, trigger_d;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      portions_d = portions_q;
      motor_d    = 1'b0;
      busy_d     = 1'b0;
      trigger_d  = trigger_q;
      unique case (state_q)
         ST_IDLE: begin
            trigger_d = 1'b0;
            // Refill has priority over a same-cycle dispense.
            if (refill_p) begin
               portions_d = P_FULL;
            end else if (disp_p && portions_q != '0) begin
               state_d = ST_DISPENSE;
               timer_d = TMR_LOAD;
               motor_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_DISPENSE: begin
            timer_d = timer_q - 1'b1;
            // Last motor cycle: consume the portion, motor off next.
            if (timer_q <= TMR_ONE) begin
               timer_d = '0;
               if (portions_q != '0) begin
                  portions_d = portions_q - 1'b1;
               end
               if (portions_q <= P_ONE) begin
                  state_d   = ST_EMPTY;
                  trigger_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               motor_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_EMPTY: begin
            trigger_d = 1'b1;
            if (refill_p) begin
               portions_d = P_FULL;
               trigger_d  = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_50mhz) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         portions_q <= P_FULL;
         motor_q    <= 1'b0;
         busy_q     <= 1'b0;
         trigger_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         portions_q <= portions_d;
         motor_q    <= motor_d;
         busy_q     <= busy_d;
         trigger_q  <= trigger_d;
      end
   end

   assign motor_en = motor_q;
   assign busy     = busy_q;
   assign portions = portions_q;
   assign trigger  = trigger_q;

endmodule

// File: tb/tb_portion_monitor.sv
// Bench for portion_monitor: scoreboard of expected dispenses.
// Raw press -> motor_en high is 8 edges (2 sync + 4 debounce + 1 edge reg + 1 FSM).
module tb_portion_monitor;

   localparam int DB   = 4;
   localparam int MOT  = 10;
   localparam int MAXP = 3;
   localparam int LAT  = 2 + DB + 1 + 1;

   logic       clk;
   logic       rst_n;
   logic       btn_dispense;
   logic       btn_refill;
   logic       motor_en;
   logic       busy;
   logic [3:0] portions;
   logic       trigger;

   portion_monitor #(
      .DEBOUNCE_CYCLES(DB),
      .MOTOR_CYCLES   (MOT),
      .MAX_PORTIONS   (MAXP),
      .CNT_W          (4)
   ) u_dut (
      .clk_50mhz   (clk),
      .rst_n       (rst_n),
      .btn_dispense(btn_dispense),
      .btn_refill  (btn_refill),
      .motor_en    (motor_en),
      .busy        (busy),
      .portions    (portions),
      .trigger     (trigger)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int portions;
      int trigger;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   run_len  = 0;
   bit   running  = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic edges_until_motor(output int n);
      n = 0;
      while (n < 50) begin
         @(posedge clk);
         #1;
         n++;
         if (motor_en) break;
      end
   endtask

   task automatic edges_until_trig_low(output int n);
      n = 0;
      while (n < 50) begin
         @(posedge clk);
         #1;
         n++;
         if (!trigger) break;
      end
   endtask

   // Each completed motor run pops one expected dispense.
   always @(negedge clk) begin
      if (!rst_n) begin
         running = 1'b0;
         run_len = 0;
      end else if (motor_en) begin
         if (!running) begin
            running = 1'b1;
            run_len = 0;
         end
         run_len++;
      end else if (running) begin
         running = 1'b0;
         chk("dispense_expected", int'(sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("motor_len", run_len, MOT);
            chk("portions_after", int'(portions), mon_e.portions);
            chk("trigger_after", int'(trigger), mon_e.trigger);
         end
      end
   end

   int n;

   initial begin
      rst_n        = 1'b0;
      btn_dispense = 1'b0;
      btn_refill   = 1'b0;
      tick(3);
      chk("rst_motor", int'(motor_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_portions", int'(portions), MAXP);
      chk("rst_trigger", int'(trigger), 0);
      rst_n = 1'b1;
      tick(5);

      // Three clean presses empty the feeder.
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back('{portions: 2 - i, trigger: (i == 2) ? 1 : 0});
         btn_dispense = 1'b1;
         edges_until_motor(n);
         chk("disp_latency", n, LAT);
         chk("busy_in_dispense", int'(busy), 1);
         btn_dispense = 1'b0;
         tick(30);
      end

      // Dispense while EMPTY is ignored.
      btn_dispense = 1'b1;
      tick(6);
      btn_dispense = 1'b0;
      tick(30);
      chk("empty_portions", int'(portions), 0);
      chk("empty_trigger", int'(trigger), 1);
      chk("empty_motor", int'(motor_en), 0);

      // Refill from EMPTY.
      btn_refill = 1'b1;
      edges_until_trig_low(n);
      chk("refill_latency", n, LAT);
      chk("refill_portions", int'(portions), MAXP);
      btn_refill = 1'b0;
      tick(20);

      // Second dispense pulse arrives mid-DISPENSE: dropped.
      sb_q.push_back('{portions: 2, trigger: 0});
      btn_dispense = 1'b1;
      tick(4);
      btn_dispense = 1'b0;
      tick(4);
      btn_dispense = 1'b1;
      tick(4);
      btn_dispense = 1'b0;
      tick(30);
      chk("redisp_portions", int'(portions), 2);

      // Refill pulse mid-DISPENSE: dropped.
      sb_q.push_back('{portions: 1, trigger: 0});
      btn_dispense = 1'b1;
      tick(4);
      btn_dispense = 1'b0;
      btn_refill   = 1'b1;
      tick(4);
      btn_refill = 1'b0;
      tick(30);
      chk("refill_in_disp", int'(portions), 1);

      // Simultaneous refill and dispense in IDLE: refill wins.
      btn_dispense = 1'b1;
      btn_refill   = 1'b1;
      tick(6);
      btn_dispense = 1'b0;
      btn_refill   = 1'b0;
      tick(30);
      chk("simul_portions", int'(portions), MAXP);
      chk("simul_motor", int'(motor_en), 0);

      // Bounce then hold: one dispense only.
      sb_q.push_back('{portions: 2, trigger: 0});
      for (int i = 0; i < 10; i++) begin
         btn_dispense = ~btn_dispense;
         tick(2);
      end
      btn_dispense = 1'b1;
      tick(40);
      btn_dispense = 1'b0;
      tick(20);

      // Three-cycle glitch: nothing.
      btn_dispense = 1'b1;
      tick(3);
      btn_dispense = 1'b0;
      tick(30);
      chk("glitch_portions", int'(portions), 2);

      // Reset in the fifth DISPENSE cycle.
      btn_dispense = 1'b1;
      edges_until_motor(n);
      chk("disp_latency2", n, LAT);
      btn_dispense = 1'b0;
      tick(4);
      rst_n = 1'b0;
      tick(1);
      chk("rst_mid_motor", int'(motor_en), 0);
      chk("rst_mid_portions", int'(portions), MAXP);
      tick(2);
      chk("rst_mid_trigger", int'(trigger), 0);
      chk("rst_mid_busy", int'(busy), 0);

      // Button held across reset release.
      btn_dispense = 1'b1;
      tick(2);
      sb_q.push_back('{portions: 2, trigger: 0});
      rst_n = 1'b1;
      edges_until_motor(n);
      chk("held_latency", n, LAT);
      tick(40);
      btn_dispense = 1'b0;
      tick(20);
      chk("held_portions", int'(portions), 2);
      chk("sb_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/portion_monitor.md
PORTION_MONITOR -- requirements
Module: portion_monitor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, stable-input cycles required before a debounced level changes (10 ms at 50 MHz).
REQ-002 SHALL have parameter MOTOR_CYCLES, default 25_000_000, cycles motor_en is held per dispense (500 ms at 50 MHz).
REQ-003 SHALL have parameter MAX_PORTIONS, default 8, portion count loaded on refill and reset.
REQ-004 SHALL have parameter CNT_W, default 4, width of portions; MAX_PORTIONS SHALL fit in CNT_W bits.
REQ-005 clk_50mhz  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 btn_dispense  input  1  raw asynchronous dispense button, active-high.
REQ-008 btn_refill  input  1  raw asynchronous refill button, active-high.
REQ-009 motor_en  output  1  dispenser motor drive, active-high.
REQ-010 busy  output  1  high while in DISPENSE.
REQ-011 portions  output  CNT_W  remaining portion count.
REQ-012 trigger  output  1  level, high while no portions remain; drives the HM-10 sender trigger input.

Function
REQ-013 Each raw button SHALL pass a 2-flop synchronizer, then a debouncer: debounced level takes the synchronized value only after DEBOUNCE_CYCLES consecutive cycles of disagreement with it; any agreement restarts the count.
REQ-014 A rising edge of a debounced level SHALL produce exactly one one-cycle pulse (disp_p, refill_p); holding a button SHALL produce no further pulses.
REQ-015 Latency raw edge -> pulse SHALL be 2 + DEBOUNCE_CYCLES cycles (+1 for the edge register), fixed and documented in the bench.
REQ-016 FSM states SHALL be IDLE, DISPENSE, EMPTY.
REQ-017 IDLE: refill_p -> portions := MAX_PORTIONS, stay IDLE; else disp_p with portions > 0 -> DISPENSE, timer := MOTOR_CYCLES.
REQ-018 refill_p and disp_p in the same IDLE cycle: refill SHALL win; the dispense SHALL be dropped.
REQ-019 DISPENSE: motor_en = 1 and busy = 1 for exactly MOTOR_CYCLES cycles, starting the cycle after disp_p; timer decrements each cycle.
REQ-020 On the final DISPENSE cycle, portions SHALL decrement by 1; next state EMPTY if new value is 0, else IDLE.
REQ-021 disp_p and refill_p during DISPENSE SHALL be ignored (no queueing).
REQ-022 EMPTY: trigger = 1, motor_en = 0; disp_p ignored; refill_p -> portions := MAX_PORTIONS, trigger := 0, next IDLE.
REQ-023 trigger SHALL rise in the first cycle after motor_en falls on the last portion and SHALL stay high until refill; it SHALL be registered, glitch-free.
REQ-024 portions SHALL never underflow below 0 nor exceed MAX_PORTIONS.

Reset
REQ-025 While rst_n = 0 at a clock edge: state IDLE, portions = MAX_PORTIONS, motor_en = 0, busy = 0, trigger = 0, timer = 0, synchronizer flops, debounce counters, debounced levels and edge registers = 0.
REQ-026 Reset asserted mid-DISPENSE SHALL drop motor_en on the next edge with no portion decrement.
REQ-027 A button already held at reset release SHALL produce a pulse only after a full debounce interval (debounced level restarts at 0).

Structure
REQ-028 FSM state encodings and default timing constants SHALL live in shared package/include feeder_pkg, reused by the top level that joins this block to the HM-10 sender.
REQ-029 Synchronizer, debouncer and edge pulse SHALL be one sub-module, btn_debounce (parameter DEBOUNCE_CYCLES), instantiated once per button.
REQ-030 Timer width SHALL be $clog2(MOTOR_CYCLES+1); debounce counter width $clog2(DEBOUNCE_CYCLES+1).

Verification (bench params: DEBOUNCE_CYCLES=4, MOTOR_CYCLES=10, MAX_PORTIONS=3)
REQ-031 Reset, then 3 clean dispense presses -> motor_en high exactly 10 cycles each; portions 3->2->1->0; trigger rises the cycle after third motor_en falls.
REQ-032 Bounce: btn_dispense toggles every 2 cycles for 20 cycles then held high -> single dispense only; 3-cycle glitch -> no dispense.
REQ-033 Press dispense during DISPENSE and in EMPTY -> ignored; portions unchanged; motor_en stays 0 in EMPTY.
REQ-034 In EMPTY press refill -> trigger falls next cycle, portions = 3, state IDLE; simultaneous refill and dispense pulses in IDLE -> portions = 3, no motor_en.
REQ-035 Assert rst_n = 0 at cycle 5 of DISPENSE with portions = 2 -> motor_en 0 next edge, portions = 3 after reset, trigger = 0.
REQ-036 Hold btn_dispense high across reset release -> exactly one dispense after 2+4+1 cycles, none further while held.
